// File: rtl/bin_act_packer.sv
// ---------------------------------------------------------------------------
// bin_act_packer
//
// Sign-activation and bit-packing stage at the output of the binary MAC
// datapath. Per-chunk popcounts are accumulated per neuron; on the neuron's
// last chunk the saturated total is compared against the neuron threshold to
// produce one activation bit. Bits are packed LSB-first into IN_WIDTH-bit
// words that are handed downstream over a valid/ready handshake as operands
// for the next layer.
//
// Parameters
//   OUTPUT_WIDTH  width of the incoming popcount
//   ACC_WIDTH     per-neuron accumulator and threshold width
//   IN_WIDTH      packed output word width (one bit per neuron)
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   pack_cnt_in     unsigned popcount of one chunk
//   pack_cnt_valid  pack_cnt_in / pack_cnt_last / pack_thresh valid
//   pack_cnt_last   beat is the final chunk of the current neuron
//   pack_thresh     neuron threshold, used only on an accepted last beat
//   pack_cnt_ready  beat (and flush) accepted when high
//   pack_flush      request to emit a partially filled word
//   pack_out        packed activations, bit i = i-th neuron of the word
//   pack_out_nbits  number of valid bits in pack_out
//   pack_out_valid  pack_out / pack_out_nbits valid
//   pack_out_ready  downstream accepts the word when valid && ready
// ---------------------------------------------------------------------------
module bin_act_packer #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int IN_WIDTH     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [OUTPUT_WIDTH-1:0]        pack_cnt_in,
    input  logic                           pack_cnt_valid,
    input  logic                           pack_cnt_last,
    input  logic [ACC_WIDTH-1:0]           pack_thresh,
    output logic                           pack_cnt_ready,
    input  logic                           pack_flush,
    output logic [IN_WIDTH-1:0]            pack_out,
    output logic [$clog2(IN_WIDTH+1)-1:0]  pack_out_nbits,
    output logic                           pack_out_valid,
    input  logic                           pack_out_ready
);

    localparam int NB_W  = $clog2(IN_WIDTH + 1);
    localparam int SUM_W = ACC_WIDTH + 1;

    localparam logic [NB_W-1:0] LAST_IDX = NB_W'(IN_WIDTH - 1);
    localparam logic [NB_W-1:0] FULL_N   = NB_W'(IN_WIDTH);

    // Output register state machine
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]            state;
    logic [ACC_WIDTH-1:0]  acc;
    logic [IN_WIDTH-1:0]   pack_reg;
    logic [NB_W-1:0]       bit_idx;

    logic                  accept;
    logic                  last_acc;
    logic [SUM_W-1:0]      sum_ext;
    logic [ACC_WIDTH-1:0]  sum_sat;
    logic                  act_bit;
    logic [IN_WIDTH-1:0]   pack_next;
    logic [NB_W-1:0]       idx_next;
    logic                  word_full;
    logic                  flush_go;
    logic                  emit;
    logic [IN_WIDTH-1:0]   emit_word;
    logic [NB_W-1:0]       emit_nbits;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A single output register: upstream may only advance when that
    // register is free or is being drained in this same cycle.
    assign pack_out_valid = (state == ST_FULL);
    assign pack_cnt_ready = !pack_out_valid || pack_out_ready;

    assign accept   = pack_cnt_valid && pack_cnt_ready;
    assign last_acc = accept && pack_cnt_last;

    // ------------------------------------------------------------------
    // Saturating accumulate and threshold
    // ------------------------------------------------------------------
    // One extra bit catches the carry out; a set carry clamps to all-ones
    // so a large total can never wrap below the threshold.
    assign sum_ext = {1'b0, acc} + SUM_W'(pack_cnt_in);
    assign sum_sat = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    assign act_bit = (sum_sat >= pack_thresh);

    // ------------------------------------------------------------------
    // Pack next state and word emission
    // ------------------------------------------------------------------
    assign idx_next  = last_acc ? bit_idx + NB_W'(1) : bit_idx;
    assign word_full = last_acc && (bit_idx == LAST_IDX);

    // A flush only counts while upstream is allowed to move, and only if
    // there is at least one bit to emit (including a bit packed this cycle).
    assign flush_go = pack_flush && pack_cnt_ready && (idx_next != '0);

    // A flush that coincides with the word-completing beat still yields a
    // single full word, so word_full takes priority in the nbits choice.
    assign emit       = word_full || flush_go;
    assign emit_nbits = word_full ? FULL_N : idx_next;

    // NOTE: every signal driven in an always_comb gets a full default before
    // any conditional update, otherwise synthesis infers a latch.
    always_comb begin
        pack_next = pack_reg;
        emit_word = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (last_acc && (bit_idx == NB_W'(i))) begin
                pack_next[i] = act_bit;
            end
            // Bits at and above the fill level are forced to zero.
            if (NB_W'(i) < emit_nbits) begin
                emit_word[i] = pack_next[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            if (pack_cnt_last) begin
                acc <= '0;
            end else begin
                acc <= sum_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packing register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg <= '0;
            bit_idx  <= '0;
        end else if (emit) begin
            pack_reg <= '0;
            bit_idx  <= '0;
        end else if (last_acc) begin
            pack_reg <= pack_next;
            bit_idx  <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Output register state machine
    // ------------------------------------------------------------------
    // emit can only be high while pack_cnt_ready is high, so loading a new
    // word never overwrites one that downstream has not taken yet. That also
    // keeps pack_out stable throughout a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_EMPTY;
            pack_out       <= '0;
            pack_out_nbits <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (emit) begin
                        state          <= ST_FULL;
                        pack_out       <= emit_word;
                        pack_out_nbits <= emit_nbits;
                    end
                end
                ST_FULL: begin
                    if (pack_out_ready) begin
                        if (emit) begin
                            // back-to-back: handshake and reload together
                            pack_out       <= emit_word;
                            pack_out_nbits <= emit_nbits;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_act_packer.sv
// ---------------------------------------------------------------------------
// tb_bin_act_packer
//
// Directed bench for bin_act_packer, configured with a 4-bit word and 8-bit
// popcount/accumulator so saturation is reachable with small numbers.
// Covers packing, multi-chunk accumulation, saturation, flush, backpressure,
// back-to-back emission and mid-word asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bin_act_packer;

    localparam int OW = 8;
    localparam int AW = 8;
    localparam int IW = 4;
    localparam int NB = $clog2(IW + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [OW-1:0]  pack_cnt_in;
    logic           pack_cnt_valid;
    logic           pack_cnt_last;
    logic [AW-1:0]  pack_thresh;
    logic           pack_cnt_ready;
    logic           pack_flush;
    logic [IW-1:0]  pack_out;
    logic [NB-1:0]  pack_out_nbits;
    logic           pack_out_valid;
    logic           pack_out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    bin_act_packer #(
        .OUTPUT_WIDTH (OW),
        .ACC_WIDTH    (AW),
        .IN_WIDTH     (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pack_cnt_in    (pack_cnt_in),
        .pack_cnt_valid (pack_cnt_valid),
        .pack_cnt_last  (pack_cnt_last),
        .pack_thresh    (pack_thresh),
        .pack_cnt_ready (pack_cnt_ready),
        .pack_flush     (pack_flush),
        .pack_out       (pack_out),
        .pack_out_nbits (pack_out_nbits),
        .pack_out_valid (pack_out_valid),
        .pack_out_ready (pack_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, hold across the
    // rising edge, sample 1ns after it, then drop the strobes.
    task automatic drive(input logic v, input logic [OW-1:0] cnt, input logic last,
                         input logic [AW-1:0] thr, input logic flush);
        @(negedge clk);
        pack_cnt_valid = v;
        pack_cnt_in    = cnt;
        pack_cnt_last  = last;
        pack_thresh    = thr;
        pack_flush     = flush;
        @(posedge clk);
        #1;
        pack_cnt_valid = 1'b0;
        pack_cnt_last  = 1'b0;
        pack_flush     = 1'b0;
    endtask

    task automatic beat(input logic [OW-1:0] cnt, input logic last, input logic [AW-1:0] thr);
        drive(1'b1, cnt, last, thr, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        pack_cnt_in    = '0;
        pack_cnt_valid = 1'b0;
        pack_cnt_last  = 1'b0;
        pack_thresh    = '0;
        pack_flush     = 1'b0;
        pack_out_ready = 1'b1;
        #1;
        check("rst_out",   32'(pack_out),       32'h0);
        check("rst_nbits", 32'(pack_out_nbits), 32'h0);
        check("rst_valid", 32'(pack_out_valid), 32'h0);
        check("rst_ready", 32'(pack_cnt_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Four single-beat neurons, thresh 5: 5,4,16,0 -> 1,0,1,0
        beat(8'd5,  1'b1, 8'd5);
        beat(8'd4,  1'b1, 8'd5);
        beat(8'd16, 1'b1, 8'd5);
        check("w1_not_yet", 32'(pack_out_valid), 32'h0);
        beat(8'd0,  1'b1, 8'd5);
        check("w1_valid", 32'(pack_out_valid), 32'h1);
        check("w1_out",   32'(pack_out),       32'h5);
        check("w1_nbits", 32'(pack_out_nbits), 32'h4);

        // Multi-chunk neurons; accumulator must restart at zero each neuron
        beat(8'd10, 1'b0, 8'd0);
        check("w1_drained", 32'(pack_out_valid), 32'h0);
        beat(8'd10, 1'b0, 8'd0);
        beat(8'd10, 1'b1, 8'd30);   // 30 >= 30 -> 1
        beat(8'd10, 1'b0, 8'd0);
        beat(8'd10, 1'b0, 8'd0);
        beat(8'd10, 1'b1, 8'd31);   // 30 <  31 -> 0
        beat(8'd5,  1'b1, 8'd6);    // 5 < 6 -> 0 only if acc was cleared
        beat(8'd200, 1'b0, 8'd0);
        beat(8'd200, 1'b1, 8'd255); // saturates at 255 -> 1
        check("w2_valid", 32'(pack_out_valid), 32'h1);
        check("w2_out",   32'(pack_out),       32'h9);
        check("w2_nbits", 32'(pack_out_nbits), 32'h4);

        // Flush of a partial word
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("fl_valid", 32'(pack_out_valid), 32'h1);
        check("fl_out",   32'(pack_out),       32'h3);
        check("fl_nbits", 32'(pack_out_nbits), 32'h2);
        drive(1'b0, '0, 1'b0, '0, 1'b1);    // empty flush does nothing
        check("fl_empty", 32'(pack_out_valid), 32'h0);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd0, 1'b1, 8'd5);
        drive(1'b1, 8'd9, 1'b1, 8'd5, 1'b1); // last beat + flush
        check("fl3_valid", 32'(pack_out_valid), 32'h1);
        check("fl3_out",   32'(pack_out),       32'h5);
        check("fl3_nbits", 32'(pack_out_nbits), 32'h3);
        idle();
        check("fl3_drained", 32'(pack_out_valid), 32'h0);

        // Backpressure
        pack_out_ready = 1'b0;
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd0, 1'b1, 8'd5);
        beat(8'd0, 1'b1, 8'd5);
        check("bp_valid", 32'(pack_out_valid), 32'h1);
        check("bp_ready", 32'(pack_cnt_ready), 32'h0);
        beat(8'd5, 1'b1, 8'd5);             // must be refused
        check("bp_hold_valid", 32'(pack_out_valid), 32'h1);
        check("bp_hold_out",   32'(pack_out),       32'h3);
        check("bp_hold_nbits", 32'(pack_out_nbits), 32'h4);
        // Release together with a new word: no bubble on valid
        pack_out_ready = 1'b1;
        drive(1'b1, 8'd5, 1'b1, 8'd5, 1'b1);
        check("b2b_valid", 32'(pack_out_valid), 32'h1);
        check("b2b_out",   32'(pack_out),       32'h1);
        check("b2b_nbits", 32'(pack_out_nbits), 32'h1);

        // Mid-word asynchronous reset
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        check("pre_rst_out", 32'(pack_out), 32'hF);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        pack_out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",   32'(pack_out),       32'h0);
        check("mid_rst_nbits", 32'(pack_out_nbits), 32'h0);
        check("mid_rst_valid", 32'(pack_out_valid), 32'h0);
        check("mid_rst_ready", 32'(pack_cnt_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        pack_out_ready = 1'b1;
        beat(8'd0, 1'b1, 8'd5);
        beat(8'd5, 1'b1, 8'd5);
        check("post_rst_not_yet", 32'(pack_out_valid), 32'h0);
        beat(8'd5, 1'b1, 8'd5);
        beat(8'd0, 1'b1, 8'd5);
        check("post_rst_valid", 32'(pack_out_valid), 32'h1);
        check("post_rst_out",   32'(pack_out),       32'h6);
        check("post_rst_nbits", 32'(pack_out_nbits), 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
